// File: rtl/rs232_rx_stream.sv
// UART receiver: 8N1 serial line to a 32-bit stb/ack stream.
// Define RS232_RX_PARITY_EN to add an even-parity bit and a parity_error port.
module rs232_rx_stream #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] out_data,
  output logic        out_stb,
  input  logic        out_ack,
  output logic        frame_error,
`ifdef RS232_RX_PARITY_EN
  output logic        parity_error,
`endif
  output logic        overrun
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
  localparam int CW             = $clog2(CLOCKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
`ifdef RS232_RX_PARITY_EN
    PARITY,
`endif
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          rx_m, rx_s;
  logic          cnt_clr, shift_en;
  logic          deliver, stop_bad;
  logic          bit_end, half_end, free;
`ifdef RS232_RX_PARITY_EN
  logic          par_bad, par_ld, perr;
`endif

  assign bit_end  = (cnt == CW'(CLOCKS_PER_BIT - 1));
  assign half_end = (cnt == CW'(HALF_BIT - 1));
  assign free     = !out_stb || out_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    stop_bad = 1'b0;
`ifdef RS232_RX_PARITY_EN
    par_ld   = 1'b0;
    perr     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        if (half_end) begin
          cnt_clr = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef RS232_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_clr = 1'b1;
          par_ld  = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            state_n = IDLE;
`ifdef RS232_RX_PARITY_EN
            deliver = !par_bad;
            perr    = par_bad;
`else
            deliver = 1'b1;
`endif
          end else begin
            // Stay in BREAK until the line recovers.
            state_n  = BREAK;
            stop_bad = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (cnt_clr || state == IDLE || state == BREAK) cnt <= '0;
      else                                            cnt <= cnt + 1'b1;
      if (state == START)  bit_cnt <= '0;
      else if (shift_en)   bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
    end
  end

`ifdef RS232_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      if (par_ld) par_bad <= ^{shift, rx_s};
      parity_error <= perr;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data    <= '0;
      out_stb     <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= stop_bad;
      overrun     <= deliver && !free;
      if (deliver && free) begin
        out_data <= {24'b0, shift};
        out_stb  <= 1'b1;
      end else if (out_ack) begin
        out_stb  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs232_rx_stream.sv
// Directed bench for rs232_rx_stream at 10 clocks per bit.
// Build with RS232_RX_PARITY_EN to also exercise the parity path.
module tb_rs232_rx_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic        out_ack = 1'b0;
  logic [31:0] out_data;
  logic        out_stb;
  logic        frame_error;
  logic        overrun;
`ifdef RS232_RX_PARITY_EN
  logic        parity_error;
`endif

  rs232_rx_stream #(
    .CLOCK_FREQUENCY(1000000),
    .BAUD_RATE(100000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .out_data(out_data),
    .out_stb(out_stb),
    .out_ack(out_ack),
    .frame_error(frame_error),
`ifdef RS232_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          rcv_cnt, ferr_cnt, ovr_cnt, perr_cnt, stb_cyc;
  logic [31:0] rcv_last;
  int          lat;

  always @(negedge clk) begin
    if (out_stb && out_ack) begin
      rcv_cnt++;
      rcv_last = out_data;
    end
    if (out_stb) stb_cyc++;
    if (frame_error) ferr_cnt++;
    if (overrun) ovr_cnt++;
`ifdef RS232_RX_PARITY_EN
    if (parity_error) perr_cnt++;
`endif
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr();
    rcv_cnt  = 0;
    ferr_cnt = 0;
    ovr_cnt  = 0;
    perr_cnt = 0;
    stb_cyc  = 0;
    rcv_last = '0;
  endtask

  // Leaves rx at the stop-bit level when done.
  task automatic send(input logic [7:0] d,
                      input logic par,
                      input logic stop);
    rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(10);
    end
`ifdef RS232_RX_PARITY_EN
    rx = par;
    tick(10);
`else
    if (par) rx = 1'b1;
`endif
    rx = stop;
    tick(10);
  endtask

  initial begin
    clr();
    tick(3);
    check("rst_stb", {31'b0, out_stb}, 0);
    check("rst_data", out_data, 0);
    check("rst_ferr", {31'b0, frame_error}, 0);
    check("rst_ovr", {31'b0, overrun}, 0);
    rst = 1'b1;
    tick(5);

    // 1: single byte, consumer always ready
    out_ack = 1'b1;
    clr();
    lat = 0;
    fork
      send(8'h55, 1'b0, 1'b1);
      begin
        while (!out_stb && lat < 150) begin
          tick(1);
          lat++;
        end
      end
    join
    tick(5);
    check("t1_lat_ok", {31'b0, (lat >= 95 && lat <= 98)}, 1);
    check("t1_count", rcv_cnt, 1);
    check("t1_data", rcv_last, 32'h55);
    check("t1_stb_width", stb_cyc, 1);
    check("t1_ferr", ferr_cnt, 0);

    // 2: consumer stalled, second byte overruns
    out_ack = 1'b0;
    clr();
    send(8'h41, 1'b0, 1'b1);
    send(8'h42, 1'b0, 1'b1);
    tick(5);
    check("t2_hold_data", out_data, 32'h41);
    check("t2_hold_stb", {31'b0, out_stb}, 1);
    check("t2_ovr", ovr_cnt, 1);
    check("t2_none_yet", rcv_cnt, 0);
    out_ack = 1'b1;
    tick(4);
    check("t2_count", rcv_cnt, 1);
    check("t2_data", rcv_last, 32'h41);
    check("t2_stb_low", {31'b0, out_stb}, 0);

    // 3: bad stop bit, line break, recovery
    clr();
    send(8'hA5, 1'b0, 1'b0);
    tick(30);
    rx = 1'b1;
    tick(5);
    check("t3_ferr", ferr_cnt, 1);
    check("t3_no_byte", rcv_cnt, 0);
    send(8'h3C, 1'b0, 1'b1);
    tick(5);
    check("t3_count", rcv_cnt, 1);
    check("t3_data", rcv_last, 32'h3C);

    // 4: short glitch is ignored
    clr();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check("t4_no_byte", rcv_cnt, 0);
    check("t4_no_stb", stb_cyc, 0);
    check("t4_ferr", ferr_cnt, 0);
    send(8'h12, 1'b0, 1'b1);
    tick(5);
    check("t4_after_count", rcv_cnt, 1);
    check("t4_after_data", rcv_last, 32'h12);

    // 5: reset mid-frame with a byte held
    out_ack = 1'b0;
    clr();
    send(8'h11, 1'b0, 1'b1);
    tick(5);
    check("t5_pre_stb", {31'b0, out_stb}, 1);
    rx = 1'b0;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b0 : 1'b1;
      tick(10);
    end
    rx = 1'b1;
    tick(5);
    rst = 1'b0;
    #1;
    check("t5_rst_stb", {31'b0, out_stb}, 0);
    check("t5_rst_data", out_data, 0);
    tick(2);
    rst = 1'b1;
    out_ack = 1'b1;
    tick(5);
    clr();
    send(8'h7E, 1'b0, 1'b1);
    tick(5);
    check("t5_count", rcv_cnt, 1);
    check("t5_data", rcv_last, 32'h7E);

`ifdef RS232_RX_PARITY_EN
    // 6: even parity good, then bad
    clr();
    send(8'h81, 1'b0, 1'b1);
    tick(5);
    check("t6_ok_count", rcv_cnt, 1);
    check("t6_ok_data", rcv_last, 32'h81);
    check("t6_ok_perr", perr_cnt, 0);
    clr();
    send(8'h81, 1'b1, 1'b1);
    tick(5);
    check("t6_bad_perr", perr_cnt, 1);
    check("t6_bad_count", rcv_cnt, 0);
    check("t6_bad_stb", stb_cyc, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
